eth_rx_header_capture: RTL and testbench



---
 rtl/eth_rx_pkg.sv | 64 ++++++
 rtl/eth_rx_header_capture_if.sv | 10 +
 rtl/eth_rx_header_capture.sv | 110 +++++++++++
 tb/tb_eth_rx_header_capture.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// Shared constants, field offsets and helpers for the Ethernet receive header path.
package eth_rx_pkg;

  localparam int ETH_HEAD_BYTES     = 42;
  localparam int AXIS_BYTES         = 8;
  localparam int HEAD_LAST_BEAT     = 5;
  localparam int HEAD_PAYLOAD_BYTES = 6;

  localparam int HEAD_BITS    = ETH_HEAD_BYTES * 8;
  localparam int AXIS_BITS    = AXIS_BYTES * 8;
  localparam int PAYLOAD_BITS = HEAD_PAYLOAD_BYTES * 8;

  // Field offsets as byte indices into o_data_head; index n covers bits [n*8-1 -: 8],
  // so index 42 is the first byte on the wire.
  localparam int OFS_DST_MAC_HI   = 42;
  localparam int OFS_DST_MAC_LO   = 37;
  localparam int OFS_SRC_MAC_HI   = 36;
  localparam int OFS_SRC_MAC_LO   = 31;
  localparam int OFS_ETYPE_HI     = 30;
  localparam int OFS_ETYPE_LO     = 29;
  localparam int OFS_ARP_OPER_HI  = 22;
  localparam int OFS_ARP_OPER_LO  = 21;
  localparam int OFS_ARP_SPA_HI   = 14;
  localparam int OFS_ARP_SPA_LO   = 11;
  localparam int OFS_ARP_TPA_HI   = 4;
  localparam int OFS_ARP_TPA_LO   = 1;
  localparam int OFS_IP_VER_IHL   = 28;
  localparam int OFS_IP_PROTO     = 19;
  localparam int OFS_IP_SRC_HI    = 16;
  localparam int OFS_IP_SRC_LO    = 13;
  localparam int OFS_IP_DST_HI    = 12;
  localparam int OFS_IP_DST_LO    = 9;
  localparam int OFS_L4_HI        = 8;
  localparam int OFS_L4_LO        = 1;

  localparam logic [47:0] FPGA_MAC = 48'h211abcdef112;
  localparam logic [31:0] FPGA_IP  = 32'hC0000186;

  // Beat position within the frame; DRAIN covers every beat after the header.
  typedef enum logic [2:0] {
    BEAT0 = 3'd0,
    BEAT1 = 3'd1,
    BEAT2 = 3'd2,
    BEAT3 = 3'd3,
    BEAT4 = 3'd4,
    BEAT5 = 3'd5,
    DRAIN = 3'd6
  } beat_state_t;

  // Reorders an AXIS beat (lane 0 in the LSBs) so lane 0 lands in the MSBs.
  function automatic logic [AXIS_BITS-1:0] lanes_to_be(input logic [AXIS_BITS-1:0] d);
    logic [AXIS_BITS-1:0] r;
    for (int j = 0; j < AXIS_BYTES; j++) begin
      r[AXIS_BITS-1-8*j -: 8] = d[8*j +: 8];
    end
    return r;
  endfunction

  // Extracts one byte of a header vector by its offset index (42 = first wire byte).
  function automatic logic [7:0] head_byte(input logic [HEAD_BITS-1:0] head, input int idx);
    return head[idx*8-1 -: 8];
  endfunction

endpackage

// File: rtl/eth_rx_header_capture_if.sv
// Receive AXI-Stream beat bundle from the MAC; no tready, the sink always accepts.
interface eth_rx_header_capture_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;

  modport master (output tvalid, output tdata, output tlast, output tkeep);
  modport slave  (input  tvalid, input  tdata, input  tlast, input  tkeep);
endinterface

// File: rtl/eth_rx_header_capture.sv
// Captures the 42-byte L2+L3 header of each received frame as a big-endian vector,
// plus the six payload bytes sharing the sixth beat.
//
// state | meaning
// BEAT0 | idle / expecting first beat of a frame (header bytes 0..7)
// BEAT1 | expecting header bytes 8..15
// BEAT2 | expecting header bytes 16..23
// BEAT3 | expecting header bytes 24..31
// BEAT4 | expecting header bytes 32..39
// BEAT5 | expecting bytes 40..41 plus payload 42..47; decides accept/discard
// DRAIN | header done, ignore beats until tlast
module eth_rx_header_capture
  import eth_rx_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  eth_rx_header_capture_if.slave     rx_axis,
  output logic [HEAD_BITS-1:0]       o_data_head,
  output logic                       o_data_head_valid,
  output logic                       o_data_head_frame_payload_valid,
  output logic [PAYLOAD_BITS-1:0]    o_data_head_frame_payload,
  output logic [HEAD_PAYLOAD_BYTES-1:0] o_data_head_frame_payload_keep
);

  beat_state_t          state_q, state_d;
  logic [HEAD_BITS-1:0] stage_q, stage_d;
  logic                 accept;

  // Beat position register; reset returns to the start of a frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= BEAT0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next beat position: tlast always rewinds, otherwise advance and park in DRAIN.
  always_comb begin
    state_d = state_q;
    if (rx_axis.tvalid) begin
      if (rx_axis.tlast) begin
        state_d = BEAT0;
      end else begin
        case (state_q)
          BEAT0:   state_d = BEAT1;
          BEAT1:   state_d = BEAT2;
          BEAT2:   state_d = BEAT3;
          BEAT3:   state_d = BEAT4;
          BEAT4:   state_d = BEAT5;
          BEAT5:   state_d = DRAIN;
          DRAIN:   state_d = DRAIN;
          default: state_d = BEAT0;
        endcase
      end
    end
  end

  // Byte-lane mux into the staging vector; tkeep is deliberately ignored here so a
  // short keep on an early beat cannot corrupt the header alignment.
  always_comb begin
    stage_d = stage_q;
    accept  = 1'b0;
    if (rx_axis.tvalid) begin
      case (state_q)
        BEAT0: stage_d[HEAD_BITS-1        -: AXIS_BITS] = lanes_to_be(rx_axis.tdata);
        BEAT1: stage_d[HEAD_BITS-1-1*64   -: AXIS_BITS] = lanes_to_be(rx_axis.tdata);
        BEAT2: stage_d[HEAD_BITS-1-2*64   -: AXIS_BITS] = lanes_to_be(rx_axis.tdata);
        BEAT3: stage_d[HEAD_BITS-1-3*64   -: AXIS_BITS] = lanes_to_be(rx_axis.tdata);
        BEAT4: stage_d[HEAD_BITS-1-4*64   -: AXIS_BITS] = lanes_to_be(rx_axis.tdata);
        BEAT5: begin
          stage_d[15:0] = {rx_axis.tdata[7:0], rx_axis.tdata[15:8]};
          accept        = (rx_axis.tkeep[1:0] == 2'b11);
        end
        default: ;
      endcase
    end
  end

  // Staging register holds through tvalid gaps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Output registers: one-cycle pulses, header and payload held until the next accept.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data_head                     <= '0;
      o_data_head_valid               <= 1'b0;
      o_data_head_frame_payload_valid <= 1'b0;
      o_data_head_frame_payload       <= '0;
      o_data_head_frame_payload_keep  <= '0;
    end else begin
      o_data_head_valid               <= 1'b0;
      o_data_head_frame_payload_valid <= 1'b0;
      if (accept) begin
        o_data_head                     <= stage_d;
        o_data_head_valid               <= 1'b1;
        o_data_head_frame_payload_valid <= |rx_axis.tkeep[7:2];
        o_data_head_frame_payload       <= rx_axis.tdata[63:16];
        o_data_head_frame_payload_keep  <= rx_axis.tkeep[7:2];
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_header_capture.sv
// Scoreboard bench: the driver pushes expected headers computed from frame byte arrays,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_eth_rx_header_capture;
  import eth_rx_pkg::*;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  eth_rx_header_capture_if rx_axis ();

  logic [335:0] o_data_head;
  logic         o_data_head_valid;
  logic         o_data_head_frame_payload_valid;
  logic [47:0]  o_data_head_frame_payload;
  logic [5:0]   o_data_head_frame_payload_keep;

  eth_rx_header_capture dut (
    .i_clk                           (i_clk),
    .i_reset                         (i_reset),
    .rx_axis                         (rx_axis.slave),
    .o_data_head                     (o_data_head),
    .o_data_head_valid               (o_data_head_valid),
    .o_data_head_frame_payload_valid (o_data_head_frame_payload_valid),
    .o_data_head_frame_payload       (o_data_head_frame_payload),
    .o_data_head_frame_payload_keep  (o_data_head_frame_payload_keep)
  );

  typedef struct {
    logic [335:0] head;
    logic [47:0]  pay;
    logic [5:0]   keep;
    logic         pv;
    int           cyc;
    bit           chk_b6;
    logic [63:0]  b6;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [335:0] held_head = '0;
  logic [47:0]  held_pay  = '0;
  logic [5:0]   held_keep = '0;

  // Current frame description: wire bytes, per-beat keep, idle cycles before each beat.
  logic [7:0] fbytes [80];
  logic [7:0] fkeep  [10];
  int         fgap   [10];
  int         fnb;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [335:0] got, input logic [335:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: consumes one expectation per pulse, otherwise checks that outputs hold.
  always @(negedge i_clk) begin
    if (i_reset) begin
      sbq.delete();
      held_head = '0;
      held_pay  = '0;
      held_keep = '0;
    end else begin
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        check("pulse_missed_cycle", 336'(cyc), 336'(sbq[0].cyc));
        void'(sbq.pop_front());
      end
      if (o_data_head_valid) begin
        check("pending_on_pulse", 336'(sbq.size() > 0), 336'(1));
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("pulse_cycle", 336'(cyc), 336'(e.cyc));
          check("head", o_data_head, e.head);
          check("payload", 336'(o_data_head_frame_payload), 336'(e.pay));
          check("payload_keep", 336'(o_data_head_frame_payload_keep), 336'(e.keep));
          check("payload_valid", 336'(o_data_head_frame_payload_valid), 336'(e.pv));
          if (e.chk_b6) check("beat6_on_bus", 336'(rx_axis.tdata), 336'(e.b6));
          held_head = e.head;
          held_pay  = e.pay;
          held_keep = e.keep;
        end
      end else begin
        check("pv_without_valid", 336'(o_data_head_frame_payload_valid), 336'(0));
        check("head_hold", o_data_head, held_head);
        check("payload_hold", 336'(o_data_head_frame_payload), 336'(held_pay));
        check("keep_hold", 336'(o_data_head_frame_payload_keep), 336'(held_keep));
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
    rx_axis.tvalid = v;
    rx_axis.tdata  = d;
    rx_axis.tkeep  = k;
    rx_axis.tlast  = l;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int b);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = fbytes[8*b + j];
    return d;
  endfunction

  task automatic setup_frame(input int nb);
    fnb = nb;
    for (int i = 0; i < 80; i++) fbytes[i] = 8'($urandom);
    for (int b = 0; b < 10; b++) begin
      fkeep[b] = 8'hFF;
      fgap[b]  = 0;
    end
  endtask

  task automatic random_frame();
    int r;
    setup_frame(int'($urandom_range(1, 9)));
    for (int b = 0; b < 10; b++) begin
      fkeep[b] = 8'($urandom);
      fgap[b]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    end
    r = int'($urandom_range(0, 3));
    case (r)
      0: fkeep[5] = 8'hFF;
      1: fkeep[5] = 8'h03;
      2: fkeep[5] = 8'($urandom);
      default: fkeep[5] = {6'($urandom), 2'b11};
    endcase
  endtask

  // Sends the described frame; abort_at >= 0 pulses reset in the middle of that beat.
  task automatic send_frame(input int abort_at);
    bit accept;
    accept = (fnb >= 6) && (fkeep[5][1:0] == 2'b11);
    for (int b = 0; b < fnb; b++) begin
      repeat (fgap[b]) drive(1'b0, 64'h0, 8'h0, 1'b0);
      if (b == abort_at) begin
        rx_axis.tvalid = 1'b1;
        rx_axis.tdata  = beat_data(b);
        rx_axis.tkeep  = fkeep[b];
        rx_axis.tlast  = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        check("rst_async_head", o_data_head, 336'(0));
        check("rst_async_valid", 336'(o_data_head_valid), 336'(0));
        check("rst_async_pv", 336'(o_data_head_frame_payload_valid), 336'(0));
        check("rst_async_pay", 336'(o_data_head_frame_payload), 336'(0));
        check("rst_async_keep", 336'(o_data_head_frame_payload_keep), 336'(0));
        rx_axis.tvalid = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        return;
      end
      if (b == 5 && accept) begin
        exp_t e;
        for (int i = 0; i < 42; i++) e.head[(42-i)*8-1 -: 8] = fbytes[i];
        for (int j = 0; j < 6; j++) e.pay[8*j +: 8] = fbytes[42+j];
        e.keep   = fkeep[5][7:2];
        e.pv     = |fkeep[5][7:2];
        e.cyc    = cyc + 1;
        e.chk_b6 = (fnb > 6) && (fgap[6] == 0);
        e.b6     = beat_data(6);
        sbq.push_back(e);
      end
      drive(1'b1, beat_data(b), fkeep[b], (b == fnb - 1));
    end
    drive(1'b0, 64'h0, 8'h0, 1'b0);
  endtask

  initial begin
    logic [63:0] arp_b0;
    logic [63:0] icmp_b5;
    i_reset = 1'b1;
    rx_axis.tvalid = 1'b0;
    rx_axis.tdata  = '0;
    rx_axis.tkeep  = '0;
    rx_axis.tlast  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_head", o_data_head, 336'(0));
    check("reset_valid", 336'(o_data_head_valid), 336'(0));
    check("reset_pay", 336'(o_data_head_frame_payload), 336'(0));
    i_reset = 1'b0;
    drive(1'b0, 64'h0, 8'h0, 1'b0);

    // ARP request, 8 beats back-to-back
    setup_frame(8);
    arp_b0 = 64'h1100_12f1_debc_1a21;
    for (int j = 0; j < 8; j++) fbytes[j] = arp_b0[8*j +: 8];
    fbytes[12] = 8'h08;
    fbytes[13] = 8'h06;
    send_frame(-1);
    check("arp_dst_mac", 336'(o_data_head[335:288]), 336'(FPGA_MAC));
    check("arp_ethertype", 336'(o_data_head[OFS_ETYPE_HI*8-1 -: 16]), 336'(16'h0806));

    // ICMP echo with full beat 5 and beat 6 following immediately
    setup_frame(9);
    icmp_b5 = 64'h4847_4645_4443_4241;
    for (int j = 0; j < 8; j++) fbytes[40+j] = icmp_b5[8*j +: 8];
    send_frame(-1);
    check("icmp_byte40", 336'(head_byte(o_data_head, 2)), 336'(8'h41));
    check("icmp_byte41", 336'(head_byte(o_data_head, 1)), 336'(8'h42));
    check("icmp_payload", 336'(o_data_head_frame_payload), 336'(48'h4847_4645_4443));

    // Frame ending on beat 5 with only header lanes, then a normal frame
    setup_frame(6);
    fkeep[5] = 8'h03;
    send_frame(-1);
    setup_frame(7);
    send_frame(-1);

    // Runt frame, then a normal frame
    setup_frame(4);
    send_frame(-1);
    setup_frame(8);
    send_frame(-1);

    // Same frame without and with a two-cycle gap between beats 2 and 3
    setup_frame(7);
    send_frame(-1);
    fgap[3] = 2;
    send_frame(-1);

    // Reset in the middle of beat 3, then a full frame
    setup_frame(8);
    send_frame(3);
    setup_frame(8);
    send_frame(-1);

    for (int n = 0; n < 60; n++) begin
      random_frame();
      send_frame(-1);
    end

    repeat (10) drive(1'b0, 64'h0, 8'h0, 1'b0);
    check("scoreboard_empty", 336'(sbq.size()), 336'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
